// File: rtl/fsm_ctrl_pkg.sv
// Shared constants and button indexing for the sequencer command front-end.
package fsm_ctrl_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int SYNC_STAGES             = 2;
    localparam int NUM_CMDS                = 3;

    typedef enum logic [1:0] {
        CMD_RESTART = 2'd0,
        CMD_PAUSE   = 2'd1,
        CMD_GOTO    = 2'd2
    } cmd_idx_e;

endpackage

// File: rtl/btn_debounce.sv
// One raw pushbutton -> synchronised, debounced, single-cycle press pulse.
module btn_debounce
    import fsm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync;
    logic                   stable;
    logic                   stable_q;
    logic [CNT_W-1:0]       cnt;

    assign sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], raw};
        end
    end

    // Counter only advances while sync disagrees with stable; any bounce back restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync == stable) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            stable <= sync;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

endmodule

// File: rtl/fsm_cmd_conditioner.sv
// Turns three raw pushbuttons into restart pulse, pause level and terminal-qualified goto.
module fsm_cmd_conditioner
    import fsm_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_restart,
    input  logic btn_pause,
    input  logic btn_goto,
    input  logic terminal,
    output logic restart,
    output logic pause,
    output logic goto_third,
    output logic goto_pending
);

    logic [NUM_CMDS-1:0] raw_vec;
    logic [NUM_CMDS-1:0] press_vec;

    assign raw_vec[CMD_RESTART] = btn_restart;
    assign raw_vec[CMD_PAUSE]   = btn_pause;
    assign raw_vec[CMD_GOTO]    = btn_goto;

    for (genvar i = 0; i < NUM_CMDS; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_vec[i]),
            .press(press_vec[i])
        );
    end

    assign restart    = press_vec[CMD_RESTART];
    // Masking with restart keeps restart and goto_third mutually exclusive.
    assign goto_third = goto_pending & terminal & ~restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause <= 1'b0;
        end else if (restart) begin
            pause <= 1'b0;
        end else if (press_vec[CMD_PAUSE]) begin
            pause <= ~pause;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            goto_pending <= 1'b0;
        end else if (restart || goto_third) begin
            goto_pending <= 1'b0;
        end else if (press_vec[CMD_GOTO]) begin
            goto_pending <= 1'b1;
        end
    end

endmodule
